instruction_fetch_unit: RTL and testbench

Fetch stage directly upstream of immediategenerator and the decoder. It holds the PC and requests 32-bit words from instruction memory over a req/ack handshake. Each fetched word is presented as inst/opcode/inst_pc with a valid/ready handshake. The execute stage redirects the PC with branch/jump targets computed from immb/immj/immi.

---
 rtl/instruction_fetch_unit.sv | 199 +++++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, fetches 32-bit words over an imem req/ack handshake and
// presents them with a valid/ready handshake. Optional macro: FETCH_MISALIGN_TRAP_EN.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [6:0]  opcode,
  output logic [31:0] inst_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        fetch_misaligned,
`endif
  output logic        fetch_error
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, ERR} state_t;

  localparam logic [31:0] NOP_C     = 32'h0000_0013;
  localparam logic [7:0]  TIMEOUT_C = 8'(IMEM_TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [6:0]  opcode_q, opcode_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        err_q, err_d;
  logic        kill_q, kill_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] tgt;
  logic        timeout;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        mis_q, mis_d;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_d     = req_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    inst_d    = inst_q;
    opcode_d  = opcode_q;
    inst_pc_d = inst_pc_q;
    err_d     = err_q;
    kill_d    = kill_q;
    cnt_d     = cnt_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    mis_d     = mis_q;
    tgt       = redirect_pc;
`else
    tgt       = redirect_pc & ~32'h3;
`endif
    timeout   = ((cnt_q + 8'd1) == TIMEOUT_C);

    case (state_q)
      IDLE: begin
        state_d = WAIT;
        req_d   = 1'b1;
        cnt_d   = 8'd0;
        addr_d  = pc_q;
        if (redirect_valid) begin
          pc_d   = tgt;
          addr_d = tgt;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d    = tgt;
          valid_d = 1'b0;
          if (imem_ack) begin
            addr_d = tgt;
            kill_d = 1'b0;
            cnt_d  = 8'd0;
          end else begin
            // Address must stay stable until ack, so the in-flight word is killed instead.
            kill_d = 1'b1;
            cnt_d  = cnt_q + 8'd1;
            if (timeout) begin
              err_d   = 1'b1;
              req_d   = 1'b0;
              state_d = ERR;
            end
          end
        end else if (imem_ack) begin
          cnt_d = 8'd0;
          if (kill_q) begin
            kill_d = 1'b0;
            addr_d = pc_q;
          end else begin
            inst_d    = imem_rdata;
            opcode_d  = imem_rdata[6:0];
            inst_pc_d = pc_q;
            valid_d   = 1'b1;
            req_d     = 1'b0;
            pc_d      = pc_q + 32'd4;
            state_d   = HOLD;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (timeout) begin
            err_d   = 1'b1;
            req_d   = 1'b0;
            state_d = ERR;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = tgt;
          addr_d  = tgt;
          valid_d = 1'b0;
          req_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = WAIT;
        end else if (inst_ready) begin
          addr_d  = pc_q;
          valid_d = 1'b0;
          req_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = WAIT;
        end
      end
      default: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase

`ifdef FETCH_MISALIGN_TRAP_EN
    // A misaligned redirect overrides whatever the state logic chose.
    if (state_q != ERR && redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      mis_d   = 1'b1;
      req_d   = 1'b0;
      valid_d = 1'b0;
      kill_d  = 1'b0;
      state_d = ERR;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      addr_q    <= RESET_PC;
      valid_q   <= 1'b0;
      inst_q    <= NOP_C;
      opcode_q  <= NOP_C[6:0];
      inst_pc_q <= RESET_PC;
      err_q     <= 1'b0;
      kill_q    <= 1'b0;
      cnt_q     <= 8'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      opcode_q  <= opcode_d;
      inst_pc_q <= inst_pc_d;
      err_q     <= err_d;
      kill_q    <= kill_d;
      cnt_q     <= cnt_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q     <= mis_d;
`endif
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign inst_valid  = valid_q;
  assign inst        = inst_q;
  assign opcode      = opcode_q;
  assign inst_pc     = inst_pc_q;
  assign fetch_error = err_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_misaligned = mis_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: accepted fetches are queued when acked
// and checked when the consumer handshake completes.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [31:0] inst_pc;
  logic        fetch_error;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] sb[$];

  instruction_fetch_unit #(.RESET_PC(32'h0000_0100), .IMEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .opcode(opcode), .inst_pc(inst_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
    .fetch_misaligned(fetch_misaligned),
`endif
    .fetch_error(fetch_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0010_0113;
    return {a[24:0], 7'b0110011};
  endfunction

  // One clock: optionally ack the pending request and optionally expect its word to be delivered.
  task automatic cyc(input bit ack, input bit push);
    imem_ack   = ack & imem_req;
    imem_rdata = mem_word(imem_addr);
    if (imem_ack && push) sb.push_back({imem_addr, mem_word(imem_addr)});
    @(posedge clk);
    #1;
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_inst_pc", inst_pc, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        check("sb_inst", inst, e[31:0]);
        check("sb_opcode", {25'd0, opcode}, {25'd0, e[6:0]});
        check("sb_inst_pc", inst_pc, e[63:32]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0;
    redirect_valid = 1'b0; redirect_pc = 32'd0; inst_ready = 1'b0;
    repeat (3) cyc(0, 0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h100);
    check("rst_inst", inst, 32'h0000_0013);
    check("rst_opcode", {25'd0, opcode}, 32'h13);
    check("rst_inst_pc", inst_pc, 32'h100);
    check("rst_err", {31'd0, fetch_error}, 32'd0);

    // First fetch
    rst = 1'b0;
    cyc(0, 0);
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h100);
    check("first_valid_early", {31'd0, inst_valid}, 32'd0);
    cyc(1, 1);
    check("first_valid", {31'd0, inst_valid}, 32'd1);
    check("first_inst", inst, 32'h0010_0113);
    check("first_opcode", {25'd0, opcode}, 32'h13);
    check("first_inst_pc", inst_pc, 32'h100);

    // Backpressure then sequential stream
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0);
      check("hold_inst", inst, 32'h0010_0113);
      check("hold_req", {31'd0, imem_req}, 32'd0);
    end
    inst_ready = 1'b1;
    cyc(0, 0);
    check("next_addr", imem_addr, 32'h104);
    for (int k = 1; k < 4; k++) begin
      cyc(1, 1);
      check("seq_inst_pc", inst_pc, 32'h100 + 32'(4 * k));
      cyc(0, 0);
    end

    // Redirect while holding
    inst_ready = 1'b0;
    cyc(1, 0);
    check("hold2_inst_pc", inst_pc, 32'h110);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    cyc(0, 0);
    check("hold_redir_valid", {31'd0, inst_valid}, 32'd0);
    check("hold_redir_addr", imem_addr, 32'h200);
    inst_ready = 1'b1;
    cyc(1, 1);
    check("hold_redir_inst_pc", inst_pc, 32'h200);
    cyc(0, 0);

    // Redirect during an outstanding request; stale word must be dropped
    cyc(0, 0);
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    cyc(0, 0);
    check("kill_addr_held", imem_addr, 32'h204);
    cyc(0, 0);
    cyc(0, 0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    check("kill_no_valid", {31'd0, inst_valid}, 32'd0);
    check("kill_new_addr", imem_addr, 32'h300);
    check("kill_req", {31'd0, imem_req}, 32'd1);
    cyc(1, 1);
    check("kill_inst_pc", inst_pc, 32'h300);
    cyc(0, 0);

    // Timeout
    for (int i = 0; i < 15; i++) cyc(0, 0);
    check("to_not_yet", {31'd0, fetch_error}, 32'd0);
    check("to_req_still", {31'd0, imem_req}, 32'd1);
    cyc(0, 0);
    check("to_err", {31'd0, fetch_error}, 32'd1);
    check("to_req", {31'd0, imem_req}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    cyc(1, 0);
    cyc(1, 0);
    check("err_sticky", {31'd0, fetch_error}, 32'd1);
    check("err_req", {31'd0, imem_req}, 32'd0);
    check("err_valid", {31'd0, inst_valid}, 32'd0);
    rst = 1'b1;
    cyc(1, 0);
    check("rst2_err", {31'd0, fetch_error}, 32'd0);
    check("rst2_addr", imem_addr, 32'h100);
    rst = 1'b0;
    cyc(0, 0);
    check("restart_addr", imem_addr, 32'h100);
    cyc(1, 1);
    check("restart_inst_pc", inst_pc, 32'h100);
    cyc(0, 0);

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h202;
    cyc(0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_flag", {31'd0, fetch_misaligned}, 32'd1);
    check("mis_req", {31'd0, imem_req}, 32'd0);
    check("mis_err", {31'd0, fetch_error}, 32'd0);
    repeat (3) cyc(1, 0);
    check("mis_req_stays", {31'd0, imem_req}, 32'd0);
    check("mis_valid", {31'd0, inst_valid}, 32'd0);
    check("mis_sticky", {31'd0, fetch_misaligned}, 32'd1);
`else
    check("align_addr_held", imem_addr, 32'h104);
    cyc(1, 0);
    check("align_addr", imem_addr, 32'h200);
    check("align_valid", {31'd0, inst_valid}, 32'd0);
    cyc(1, 1);
    check("align_inst_pc", inst_pc, 32'h200);
    cyc(0, 0);
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
